// File: rtl/keccak_squeeze_buffer.sv
// rtl/keccak_squeeze_buffer.sv - parallel-load, word-serial output buffer for the SHAKE squeeze phase
//
// Purpose: takes one rate-sized block of Keccak state in parallel and streams it
// out as W-bit words over a valid/ready handshake. It also tracks the remaining
// output length and zero-masks the final partial word. Empty, last-word and
// last-block status go back to the Keccak FSM.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   len_we               latch output_length_i / mode_i (aborts a held block)
//   output_length_i      requested output length in bits
//   mode_i               0 = SHAKE128 (21-word rate), 1 = SHAKE256 (17-word rate)
//   block_we, block_i    parallel block load; word k = block_i[k*W +: W]
//   ready_i              consumer accepts data_o
//   data_o, valid_o      current output word and its valid
//   last_output_word     current word is the final word of the whole output
//   last_output_block    remaining length fits in one rate block
//   output_buffer_empty  no words pending
//   done_o               one-cycle pulse after the final word is transferred

module keccak_squeeze_buffer #(
    parameter int W          = 64,
    parameter int RATE_WORDS = 21,
    parameter int LEN_W      = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    len_we,
    input  logic [LEN_W-1:0]        output_length_i,
    input  logic                    mode_i,
    input  logic                    block_we,
    input  logic [RATE_WORDS*W-1:0] block_i,
    input  logic                    ready_i,
    output logic [W-1:0]            data_o,
    output logic                    valid_o,
    output logic                    last_output_word,
    output logic                    last_output_block,
    output logic                    output_buffer_empty,
    output logic                    done_o
);

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam int                SHAKE256_WORDS = 17;
    localparam int                CNT_W          = $clog2(RATE_WORDS + 1);
    localparam logic [LEN_W-1:0]  W_LEN          = LEN_W'(W);

    state_t                  state_q, state_d;
    logic [RATE_WORDS*W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]        word_cnt_q, word_cnt_d;
    logic [LEN_W-1:0]        remaining_q, remaining_d;
    logic                    mode_q, mode_d;
    logic                    done_q, done_d;

    // Length/mode as seen by a block load this cycle: a same-cycle len_we wins.
    logic [LEN_W-1:0] eff_rem;
    logic             eff_mode;
    logic [CNT_W-1:0] eff_rate;
    logic [LEN_W-1:0] words_needed;
    logic [CNT_W-1:0] load_cnt;
    logic [LEN_W-1:0] step;
    logic [LEN_W-1:0] rate_bits;
    logic [W-1:0]     mask;
    logic             xfer;

    always_comb begin
        eff_rem      = len_we ? output_length_i : remaining_q;
        eff_mode     = len_we ? mode_i : mode_q;
        eff_rate     = eff_mode ? CNT_W'(SHAKE256_WORDS) : CNT_W'(RATE_WORDS);
        words_needed = (eff_rem / W_LEN) + (((eff_rem % W_LEN) != '0) ? LEN_W'(1) : '0);
        load_cnt     = (words_needed >= LEN_W'(eff_rate)) ? eff_rate : words_needed[CNT_W-1:0];
        xfer         = (state_q == HOLD) && ready_i;
        // Saturating decrement amount: never step past zero.
        step         = (remaining_q >= W_LEN) ? W_LEN : remaining_q;
    end

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        word_cnt_d  = word_cnt_q;
        remaining_d = remaining_q;
        mode_d      = mode_q;
        done_d      = 1'b0;

        if (len_we) begin
            // New transaction: any held block is dropped.
            remaining_d = output_length_i;
            mode_d      = mode_i;
            state_d     = EMPTY;
            word_cnt_d  = '0;
        end else if (xfer) begin
            shreg_d     = shreg_q >> W;
            word_cnt_d  = word_cnt_q - CNT_W'(1);
            remaining_d = remaining_q - step;
            if (word_cnt_q == CNT_W'(1)) begin
                state_d = EMPTY;
            end
            if ((remaining_q != '0) && (remaining_q <= W_LEN)) begin
                done_d = 1'b1;
            end
        end

        // Loads only into an empty buffer (len_we empties it first); never a
        // same-cycle refill on the final transfer since that cycle is still HOLD.
        if (block_we && ((state_q == EMPTY) || len_we) && (eff_rem != '0)) begin
            shreg_d    = block_i;
            word_cnt_d = load_cnt;
            state_d    = HOLD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            shreg_q     <= '0;
            word_cnt_q  <= '0;
            remaining_q <= '0;
            mode_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            word_cnt_q  <= word_cnt_d;
            remaining_q <= remaining_d;
            mode_q      <= mode_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        rate_bits = mode_q ? LEN_W'(SHAKE256_WORDS * W) : LEN_W'(RATE_WORDS * W);
        // Keep only the bits still owed to the user in the final partial word.
        mask      = (remaining_q >= W_LEN) ? {W{1'b1}} : ~({W{1'b1}} << remaining_q);
    end

    assign valid_o             = (state_q == HOLD);
    assign output_buffer_empty = (state_q == EMPTY);
    assign data_o              = (state_q == HOLD) ? (shreg_q[W-1:0] & mask) : '0;
    assign last_output_word    = (state_q == HOLD) && (remaining_q <= W_LEN);
    assign last_output_block   = (remaining_q <= rate_bits);
    assign done_o              = done_q;

endmodule

// File: tb/tb_keccak_squeeze_buffer.sv
// tb/tb_keccak_squeeze_buffer.sv - directed self-checking bench for keccak_squeeze_buffer

module tb_keccak_squeeze_buffer;

    localparam int W  = 64;
    localparam int RW = 21;
    localparam int LW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            len_we = 1'b0;
    logic [LW-1:0]   output_length_i = '0;
    logic            mode_i = 1'b0;
    logic            block_we = 1'b0;
    logic [RW*W-1:0] block_i = '0;
    logic            ready_i = 1'b0;
    logic [W-1:0]    data_o;
    logic            valid_o;
    logic            last_output_word;
    logic            last_output_block;
    logic            output_buffer_empty;
    logic            done_o;

    int checks = 0;
    int errors = 0;

    keccak_squeeze_buffer #(.W(W), .RATE_WORDS(RW), .LEN_W(LW)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .len_we              (len_we),
        .output_length_i     (output_length_i),
        .mode_i              (mode_i),
        .block_we            (block_we),
        .block_i             (block_i),
        .ready_i             (ready_i),
        .data_o              (data_o),
        .valid_o             (valid_o),
        .last_output_word    (last_output_word),
        .last_output_block   (last_output_block),
        .output_buffer_empty (output_buffer_empty),
        .done_o              (done_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic v, input logic [63:0] d,
                             input logic low, input logic lob, input logic emp, input logic dn);
        check({tag, ".valid"}, 64'(valid_o), 64'(v));
        check({tag, ".data"}, data_o, d);
        check({tag, ".last_word"}, 64'(last_output_word), 64'(low));
        check({tag, ".last_block"}, 64'(last_output_block), 64'(lob));
        check({tag, ".empty"}, 64'(output_buffer_empty), 64'(emp));
        check({tag, ".done"}, 64'(done_o), 64'(dn));
    endtask

    function automatic logic [RW*W-1:0] mk_block(input int base);
        logic [RW*W-1:0] b;
        b = '0;
        for (int k = 0; k < RW; k++) b[k*W +: W] = 64'(base + k);
        return b;
    endfunction

    task automatic set_len(input int len, input logic mode);
        len_we = 1'b1;
        output_length_i = LW'(len);
        mode_i = mode;
        tick();
        len_we = 1'b0;
    endtask

    task automatic load(input logic [RW*W-1:0] b);
        block_we = 1'b1;
        block_i = b;
        tick();
        block_we = 1'b0;
    endtask

    initial begin
        logic [RW*W-1:0] blk;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_all("reset", 1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0);

        // SHAKE128, 256 bits, words 1..4, ready always high
        set_len(256, 1'b0);
        check("t1.lob_after_len", 64'(last_output_block), 64'd1);
        ready_i = 1'b1;
        load(mk_block(1));
        for (int i = 1; i <= 4; i++) begin
            check_all($sformatf("t1.w%0d", i), 1'b1, 64'(i), (i == 4), 1'b1, 1'b0, 1'b0);
            tick();
        end
        check_all("t1.done", 1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        check("t1.done_clear", 64'(done_o), 64'd0);

        // SHAKE256, 2176 bits = two full 17-word blocks
        set_len(2176, 1'b1);
        check("t2.lob_first", 64'(last_output_block), 64'd0);
        load(mk_block(100));
        for (int i = 0; i < 17; i++) begin
            check($sformatf("t2.b0w%0d.data", i), data_o, 64'(100 + i));
            check($sformatf("t2.b0w%0d.low", i), 64'(last_output_word), 64'd0);
            tick();
        end
        check_all("t2.between", 1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        load(mk_block(200));
        for (int i = 0; i < 17; i++) begin
            check($sformatf("t2.b1w%0d.data", i), data_o, 64'(200 + i));
            check($sformatf("t2.b1w%0d.low", i), 64'(last_output_word), 64'(i == 16));
            tick();
        end
        check_all("t2.done", 1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 1'b1);

        // 100 bits: second word masked to 36 bits
        set_len(100, 1'b0);
        blk = '0;
        blk[0 +: W] = 64'd5;
        blk[W +: W] = {W{1'b1}};
        load(blk);
        check_all("t3.w0", 1'b1, 64'd5, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check_all("t3.w1", 1'b1, 64'h0000_000F_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check_all("t3.done", 1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 1'b1);

        // Backpressure: ready 1,0,0,1,1,1
        set_len(256, 1'b0);
        ready_i = 1'b0;
        load(mk_block(11));
        check_all("t4.s0", 1'b1, 64'd11, 1'b0, 1'b1, 1'b0, 1'b0);
        ready_i = 1'b1; tick();
        check_all("t4.s1", 1'b1, 64'd12, 1'b0, 1'b1, 1'b0, 1'b0);
        ready_i = 1'b0; tick();
        check_all("t4.s2", 1'b1, 64'd12, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check_all("t4.s3", 1'b1, 64'd12, 1'b0, 1'b1, 1'b0, 1'b0);
        ready_i = 1'b1; tick();
        check_all("t4.s4", 1'b1, 64'd13, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check_all("t4.s5", 1'b1, 64'd14, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check_all("t4.done", 1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 1'b1);

        // block_we while holding is ignored
        set_len(256, 1'b0);
        ready_i = 1'b0;
        load(mk_block(21));
        load(mk_block(90));
        check_all("t5.hold_ignore", 1'b1, 64'd21, 1'b0, 1'b1, 1'b0, 1'b0);
        ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t5.w%0d", i), data_o, 64'(21 + i));
            tick();
        end
        check("t5.done", 64'(done_o), 64'd1);

        // Zero length: block_we ignored
        set_len(0, 1'b0);
        load(mk_block(60));
        check_all("t5.len0", 1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Reset after 2 of 4 words
        set_len(256, 1'b0);
        ready_i = 1'b1;
        load(mk_block(31));
        check("t6.w0", data_o, 64'd31);
        tick();
        check("t6.w1", data_o, 64'd32);
        tick();
        check("t6.w2", data_o, 64'd33);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all("t6.after_rst", 1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        // remaining is zero after reset, so a load must be ignored
        load(mk_block(35));
        check_all("t6.rem0", 1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0);

        // len_we in HOLD aborts the block; reload uses the new 128-bit length
        set_len(256, 1'b0);
        ready_i = 1'b0;
        load(mk_block(41));
        check("t7.held", data_o, 64'd41);
        set_len(128, 1'b0);
        check_all("t7.abort", 1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        load(mk_block(51));
        check_all("t7.w0", 1'b1, 64'd51, 1'b0, 1'b1, 1'b0, 1'b0);
        ready_i = 1'b1; tick();
        check_all("t7.w1", 1'b1, 64'd52, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check_all("t7.done", 1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 1'b1);

        // len_we and block_we together: load uses the new length
        ready_i = 1'b0;
        len_we = 1'b1;
        output_length_i = LW'(64);
        mode_i = 1'b0;
        block_we = 1'b1;
        block_i = mk_block(77);
        tick();
        len_we = 1'b0;
        block_we = 1'b0;
        check_all("t8.same_cycle", 1'b1, 64'd77, 1'b1, 1'b1, 1'b0, 1'b0);
        ready_i = 1'b1; tick();
        check_all("t8.done", 1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
